// File: rtl/fifo_out_if.sv
// Block-in / word-out handshake between the AES top level and the TX output buffer.
// The master side pushes 128-bit blocks and pops 32-bit words; the slave side is the buffer.
interface fifo_out_if #(
  parameter int CW = 4
);
  logic           write_en;
  logic [127:0]   data_in;
  logic           read_en;
  logic           clear_err;
  logic [31:0]    data_out;
  logic           fifo_empty;
  logic           fifo_full;
  logic [CW-1:0]  words_avail;
  logic           overflow;
  logic           underflow;

  modport master (
    output write_en, data_in, read_en, clear_err,
    input  data_out, fifo_empty, fifo_full, words_avail, overflow, underflow
  );

  modport slave (
    input  write_en, data_in, read_en, clear_err,
    output data_out, fifo_empty, fifo_full, words_avail, overflow, underflow
  );
endinterface

// File: rtl/fifo_out.sv
// TX output buffer: stores whole 128-bit AES result blocks and drains them as four
// 32-bit words, most significant word first, with show-ahead on data_out.
module fifo_out #(
  parameter int DEPTH = 2,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  fifo_out_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [BW-1:0] cnt_t;

  logic [127:0] mem_q [DEPTH];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  logic [1:0]   word_sel_q, word_sel_d;
  cnt_t         block_count_q, block_count_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;

  logic         empty, full;
  logic         wr_acc, rd_acc, rd_free;
  logic [127:0] head;

  // Full/empty come from the block count only, so equal pointers are never ambiguous.
  assign empty   = (block_count_q == '0);
  assign full    = (block_count_q == cnt_t'(DEPTH));
  assign wr_acc  = bus.write_en & ~full;
  assign rd_acc  = bus.read_en & ~empty;
  assign rd_free = rd_acc & (word_sel_q == 2'd3);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    word_sel_d    = word_sel_q;
    block_count_d = block_count_q;
    overflow_d    = overflow_q | (bus.write_en & full);
    underflow_d   = underflow_q | (bus.read_en & empty);

    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) word_sel_d = word_sel_q + 2'd1;
    if (rd_free) rd_ptr_d = rd_ptr_q + ptr_t'(1);

    case ({wr_acc, rd_free})
      2'b10:   block_count_d = block_count_q + cnt_t'(1);
      2'b01:   block_count_d = block_count_q - cnt_t'(1);
      default: block_count_d = block_count_q;
    endcase

    if (bus.clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!n_rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      word_sel_q    <= '0;
      block_count_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      word_sel_q    <= word_sel_d;
      block_count_q <= block_count_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // NOTE: block storage is deliberately not reset; stale slots are unreachable once block_count is zero.
  always_ff @(posedge clk) begin
    if (n_rst && wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    bus.data_out = 32'h0;
    if (!empty) begin
      case (word_sel_q)
        2'd0:    bus.data_out = head[127:96];
        2'd1:    bus.data_out = head[95:64];
        2'd2:    bus.data_out = head[63:32];
        default: bus.data_out = head[31:0];
      endcase
    end
  end

  assign bus.fifo_empty  = empty;
  assign bus.fifo_full   = full;
  assign bus.words_avail = CW'({block_count_q, 2'b00}) - CW'(word_sel_q);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_fifo_out.sv
// Self-checking bench for fifo_out: directed scenarios plus a random run against a
// word-queue reference model.
module tb_fifo_out;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int OW    = 32 + 2 + CW + 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fifo_out_if #(.CW(CW)) bus ();

  fifo_out #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: the buffer seen as a plain queue of pending words.
  logic [31:0] mq[$];
  logic        m_ov = 1'b0;
  logic        m_un = 1'b0;

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    return b[127-32*i -: 32];
  endfunction

  function automatic logic [OW-1:0] model_vec();
    logic [31:0] h;
    h = (mq.size() == 0) ? 32'h0 : mq[0];
    return {h, (mq.size() == 0), (((mq.size() + 3) / 4) == DEPTH), CW'(mq.size()), m_ov, m_un};
  endfunction

  function automatic logic [OW-1:0] dut_vec();
    return {bus.data_out, bus.fifo_empty, bus.fifo_full, bus.words_avail, bus.overflow, bus.underflow};
  endfunction

  task automatic apply(input logic w, input logic [127:0] d, input logic r,
                       input logic c, input logic rst_n_val);
    bit full_m, empty_m, wacc, racc;
    bus.write_en  = w;
    bus.data_in   = d;
    bus.read_en   = r;
    bus.clear_err = c;
    n_rst         = rst_n_val;
    @(posedge clk);
    if (!rst_n_val) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      full_m  = (((mq.size() + 3) / 4) == DEPTH);
      empty_m = (mq.size() == 0);
      wacc    = w && !full_m;
      racc    = r && !empty_m;
      if (racc) void'(mq.pop_front());
      if (wacc) for (int i = 0; i < 4; i++) mq.push_back(word_of(d, i));
      if (c) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end else begin
        m_ov = m_ov | (w && full_m);
        m_un = m_un | (r && empty_m);
      end
    end
    #1;
    bus.write_en  = 1'b0;
    bus.read_en   = 1'b0;
    bus.clear_err = 1'b0;
    n_rst         = 1'b1;
  endtask

  localparam logic [OW-1:0] DEF_VEC = {32'h0, 1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b0};

  task automatic test_reset();
    apply(0, '0, 0, 0, 0);
    apply(0, '0, 0, 0, 1);
    n_vec++;
    if (dut_vec() !== DEF_VEC) begin
      n_miss++;
      $display("FAIL reset_defaults: got %h expected %h", dut_vec(), DEF_VEC);
    end
  endtask

  task automatic test_word_order();
    logic [127:0] blk = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
    logic [31:0]  exp_w [4] = '{32'hdeb0f813, 32'h41f3503a, 32'h7cd01e2b, 32'hc7cdd556};
    apply(0, '0, 0, 0, 0);
    apply(1, blk, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.data_out !== exp_w[i] || bus.words_avail !== CW'(4 - i)) begin
        n_miss++;
        $display("FAIL word_order[%0d]: got %h/%0d expected %h/%0d",
                 i, bus.data_out, bus.words_avail, exp_w[i], 4 - i);
      end
      apply(0, '0, 1, 0, 1);
    end
    n_vec++;
    if (bus.fifo_empty !== 1'b1 || bus.words_avail !== '0 || bus.data_out !== 32'h0) begin
      n_miss++;
      $display("FAIL word_order_empty: got empty=%b avail=%0d data=%h expected 1/0/0",
               bus.fifo_empty, bus.words_avail, bus.data_out);
    end
  endtask

  task automatic test_fill_overflow();
    logic [127:0] a = 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D;
    logic [127:0] b = 128'h67928dd5470d4a11f0ea4ae7d49b2dd4;
    logic [31:0]  exp_w;
    apply(0, '0, 0, 0, 0);
    apply(1, a, 0, 0, 1);
    apply(1, b, 0, 0, 1);
    n_vec++;
    if (bus.fifo_full !== 1'b1) begin
      n_miss++;
      $display("FAIL fill_full: got %b expected 1", bus.fifo_full);
    end
    apply(1, {4{32'h5a5a_a5a5}}, 0, 0, 1);
    n_vec++;
    if (bus.overflow !== 1'b1 || bus.words_avail !== CW'(8) || bus.data_out !== 32'h7D8AE0F7) begin
      n_miss++;
      $display("FAIL overflow: got ov=%b avail=%0d data=%h expected 1/8/7d8ae0f7",
               bus.overflow, bus.words_avail, bus.data_out);
    end
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 4) ? word_of(a, i) : word_of(b, i - 4);
      n_vec++;
      if (bus.data_out !== exp_w || bus.fifo_empty !== 1'b0) begin
        n_miss++;
        $display("FAIL fill_drain[%0d]: got %h empty=%b expected %h empty=0",
                 i, bus.data_out, bus.fifo_empty, exp_w);
      end
      apply(0, '0, 1, 0, 1);
    end
    apply(0, '0, 0, 1, 1);
    n_vec++;
    if (bus.overflow !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      n_miss++;
      $display("FAIL overflow_clear: got ov=%b empty=%b expected 0/1", bus.overflow, bus.fifo_empty);
    end
  endtask

  task automatic test_wrap();
    logic [127:0] x = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] y = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] e = 128'hE6FEBF30133874EBCB49226CD36D0D4F;
    logic [31:0]  exp_w;
    apply(0, '0, 0, 0, 0);
    apply(1, x, 0, 0, 1);
    apply(1, y, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply(0, '0, 1, 0, 1);
    apply(1, e, 1, 0, 1);
    n_vec++;
    if (bus.fifo_full !== 1'b0 || bus.words_avail !== CW'(4) || bus.overflow !== 1'b1
        || bus.data_out !== word_of(y, 0)) begin
      n_miss++;
      $display("FAIL wrap_same_cycle: got full=%b avail=%0d ov=%b data=%h expected 0/4/1/%h",
               bus.fifo_full, bus.words_avail, bus.overflow, bus.data_out, word_of(y, 0));
    end
    apply(1, e, 0, 0, 1);
    n_vec++;
    if (bus.fifo_full !== 1'b1 || bus.words_avail !== CW'(8)) begin
      n_miss++;
      $display("FAIL wrap_retry: got full=%b avail=%0d expected 1/8", bus.fifo_full, bus.words_avail);
    end
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 4) ? word_of(y, i) : word_of(e, i - 4);
      n_vec++;
      if (bus.data_out !== exp_w) begin
        n_miss++;
        $display("FAIL wrap_drain[%0d]: got %h expected %h", i, bus.data_out, exp_w);
      end
      apply(0, '0, 1, 0, 1);
    end
    n_vec++;
    if (bus.fifo_empty !== 1'b1) begin
      n_miss++;
      $display("FAIL wrap_empty: got %b expected 1", bus.fifo_empty);
    end
  endtask

  task automatic test_underflow();
    apply(0, '0, 0, 0, 0);
    apply(0, '0, 1, 0, 1);
    n_vec++;
    if (dut_vec() !== {32'h0, 1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL underflow_set: got %h expected %h", dut_vec(),
               {32'h0, 1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b1});
    end
    apply(0, '0, 1, 1, 1);
    n_vec++;
    if (bus.underflow !== 1'b0) begin
      n_miss++;
      $display("FAIL underflow_clear: got %b expected 0", bus.underflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] c = {$urandom, $urandom, $urandom, $urandom};
    apply(0, '0, 0, 0, 0);
    apply(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
    apply(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
    for (int i = 0; i < 5; i++) apply(0, '0, 1, 0, 1);
    apply(1, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
    n_vec++;
    if (dut_vec() !== DEF_VEC) begin
      n_miss++;
      $display("FAIL reset_mid_drain: got %h expected %h", dut_vec(), DEF_VEC);
    end
    apply(1, c, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.data_out !== word_of(c, i) || bus.words_avail !== CW'(4 - i)) begin
        n_miss++;
        $display("FAIL post_reset_drain[%0d]: got %h/%0d expected %h/%0d",
                 i, bus.data_out, bus.words_avail, word_of(c, i), 4 - i);
      end
      apply(0, '0, 1, 0, 1);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_v;
    apply(0, '0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 99) < 45, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5,
            !($urandom_range(0, 199) == 0));
      exp_v = model_vec();
      n_vec++;
      if (dut_vec() !== exp_v) begin
        n_miss++;
        $display("FAIL random[%0d]: got %h expected %h", n, dut_vec(), exp_v);
      end
    end
  endtask

  initial begin
    bus.write_en  = 1'b0;
    bus.data_in   = '0;
    bus.read_en   = 1'b0;
    bus.clear_err = 1'b0;
    test_reset();
    test_word_order();
    test_fill_overflow();
    test_wrap();
    test_underflow();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
